// File: rtl/trng_pkg.sv
// ============================================================================
//  Module   : trng_pkg
//  Purpose  : Shared state encoding and default parameters for trng_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package trng_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam int c_WORD_W_DEF   = 32;
    localparam int c_WARMUP_DEF   = 64;
    localparam int c_RC_LIMIT_DEF = 34;
    localparam int c_DROP_W_DEF   = 8;

endpackage

`default_nettype wire

// File: rtl/trng_rc_health.sv
// ============================================================================
//  Module   : trng_rc_health
//  Purpose  : Repetition-count health test; trip flags the bit that completes
//             a run of RC_LIMIT identical bits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trng_rc_health
    import trng_pkg::*;
#(
    parameter int RC_LIMIT = c_RC_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic bit_valid,
    input  logic bit_in,
    output logic trip
);

    localparam int c_CW = $clog2(RC_LIMIT + 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_last;
    logic [c_CW-1:0] w_cnt_nxt;

    // A zero count marks "no previous bit", so the first bit always starts a run of 1.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bit_valid) begin
            if ((r_cnt != '0) && (bit_in == r_last)) begin
                if (r_cnt != c_CW'(RC_LIMIT)) begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end else begin
                w_cnt_nxt = c_CW'(1);
            end
        end
    end

    assign trip = bit_valid && (w_cnt_nxt == c_CW'(RC_LIMIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_last <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_last <= 1'b0;
        end else if (bit_valid) begin
            r_cnt  <= w_cnt_nxt;
            r_last <= bit_in;
        end
    end

endmodule

`default_nettype wire

// File: rtl/trng_ctrl.sv
// ============================================================================
//  Module   : trng_ctrl
//  Purpose  : Sequencer, warm-up discard, word packer and valid/ready output
//             scheduler for the trng core. Optional TRNG_CTRL_ONES_CNT_EN adds
//             the word_ones population-count output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trng_ctrl
    import trng_pkg::*;
#(
    parameter int WORD_W   = c_WORD_W_DEF,
    parameter int WARMUP   = c_WARMUP_DEF,
    parameter int RC_LIMIT = c_RC_LIMIT_DEF,
    parameter int DROP_W   = c_DROP_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       clear_fault,
    output logic                       trng_reset,
    input  logic                       trng_out_valid,
    input  logic                       trng_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [WORD_W-1:0]          word_data,
`ifdef TRNG_CTRL_ONES_CNT_EN
    output logic [$clog2(WORD_W+1)-1:0] word_ones,
`endif
    output logic                       fault,
    output logic                       busy,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int c_PCW     = $clog2(WORD_W);
    localparam int c_WUW     = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int c_WU_LAST = (WARMUP > 0) ? (WARMUP - 1) : 0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WUW-1:0]    r_wu_cnt;
    logic [WORD_W-1:0]   r_pack;
    logic [c_PCW-1:0]    r_pack_cnt;
    logic                r_trng_reset;
    logic                r_word_valid;
    logic [WORD_W-1:0]   r_word_data;
    logic                r_fault;
    logic                r_busy;
    logic [DROP_W-1:0]   r_drop_cnt;

    logic                w_bit_run;
    logic                w_trip;
    logic                w_last_bit;
    logic                w_complete;
    logic                w_load;
    logic                w_drop;
    logic                w_xfer;
    logic [WORD_W-1:0]   w_word;

    // Bits only reach the packer and health test while running and still enabled.
    assign w_bit_run  = (r_state == trng_pkg::RUN) && enable && trng_out_valid;
    assign w_last_bit = (r_pack_cnt == c_PCW'(WORD_W - 1));
    assign w_word     = r_pack | (WORD_W'(trng_out) << r_pack_cnt);
    assign w_complete = w_bit_run && !w_trip && w_last_bit;
    assign w_xfer     = r_word_valid && word_ready;
    assign w_load     = w_complete && (!r_word_valid || word_ready);
    assign w_drop     = w_complete && !w_load;

    trng_rc_health #(
        .RC_LIMIT (RC_LIMIT)
    ) u_rc_health (
        .clk       (clk),
        .reset     (reset),
        .clr       (r_state == trng_pkg::IDLE),
        .bit_valid (w_bit_run),
        .bit_in    (trng_out),
        .trip      (w_trip)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            trng_pkg::IDLE: begin
                if (enable) w_state_nxt = trng_pkg::WARMUP;
            end
            trng_pkg::WARMUP: begin
                if (!enable) begin
                    w_state_nxt = trng_pkg::IDLE;
                end else if (WARMUP == 0) begin
                    w_state_nxt = trng_pkg::RUN;
                end else if (trng_out_valid && (r_wu_cnt == c_WUW'(c_WU_LAST))) begin
                    w_state_nxt = trng_pkg::RUN;
                end
            end
            trng_pkg::RUN: begin
                if (!enable)     w_state_nxt = trng_pkg::IDLE;
                else if (w_trip) w_state_nxt = trng_pkg::FAULT;
            end
            trng_pkg::FAULT: begin
                if (clear_fault) w_state_nxt = trng_pkg::IDLE;
            end
        endcase
    end

`ifdef TRNG_CTRL_ONES_CNT_EN
    localparam int c_OW = $clog2(WORD_W + 1);
    logic [c_OW-1:0] r_ones_acc;
    logic [c_OW-1:0] r_word_ones;
    logic [c_OW-1:0] w_ones_nxt;

    assign w_ones_nxt = r_ones_acc + c_OW'(trng_out);
    assign word_ones  = r_word_ones;

    // Running count mirrors the pack register: cleared whenever the pack is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ones_acc  <= '0;
            r_word_ones <= '0;
        end else begin
            if (r_state != trng_pkg::RUN || !enable || w_trip) begin
                r_ones_acc <= '0;
            end else if (trng_out_valid) begin
                r_ones_acc <= w_last_bit ? '0 : w_ones_nxt;
            end
            if (w_load) r_word_ones <= w_ones_nxt;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= trng_pkg::IDLE;
            r_trng_reset <= 1'b1;
            r_fault      <= 1'b0;
            r_busy       <= 1'b0;
            r_wu_cnt     <= '0;
            r_pack       <= '0;
            r_pack_cnt   <= '0;
            r_word_valid <= 1'b0;
            r_word_data  <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_trng_reset <= (w_state_nxt == trng_pkg::IDLE) || (w_state_nxt == trng_pkg::FAULT);
            r_fault      <= (w_state_nxt == trng_pkg::FAULT);
            r_busy       <= (w_state_nxt == trng_pkg::WARMUP) || (w_state_nxt == trng_pkg::RUN);

            case (r_state)
                trng_pkg::IDLE: begin
                    if (enable) begin
                        r_wu_cnt   <= '0;
                        r_pack     <= '0;
                        r_pack_cnt <= '0;
                    end
                end
                trng_pkg::WARMUP: begin
                    if (enable && trng_out_valid) r_wu_cnt <= r_wu_cnt + c_WUW'(1);
                end
                trng_pkg::RUN: begin
                    if (!enable || w_trip) begin
                        r_pack     <= '0;
                        r_pack_cnt <= '0;
                    end else if (trng_out_valid) begin
                        if (w_last_bit) begin
                            r_pack     <= '0;
                            r_pack_cnt <= '0;
                        end else begin
                            r_pack     <= w_word;
                            r_pack_cnt <= r_pack_cnt + c_PCW'(1);
                        end
                    end
                end
                default: begin
                    r_pack     <= '0;
                    r_pack_cnt <= '0;
                end
            endcase

            if (w_load) begin
                r_word_valid <= 1'b1;
                r_word_data  <= w_word;
            end else if (w_xfer) begin
                r_word_valid <= 1'b0;
            end

            if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

    assign trng_reset = r_trng_reset;
    assign word_valid = r_word_valid;
    assign word_data  = r_word_data;
    assign fault      = r_fault;
    assign busy       = r_busy;
    assign drop_cnt   = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_trng_ctrl.sv
// ============================================================================
//  Module   : tb_trng_ctrl
//  Purpose  : Self-checking bench for trng_ctrl (WORD_W=8, WARMUP=4,
//             RC_LIMIT=5, DROP_W=2); TRNG_CTRL_ONES_CNT_EN also checks word_ones.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trng_ctrl;

    localparam int c_WW  = 8;
    localparam int c_WU  = 4;
    localparam int c_RCL = 5;
    localparam int c_DW  = 2;
    localparam int c_OW  = $clog2(c_WW + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              clear_fault = 1'b0;
    logic              trng_out_valid = 1'b0;
    logic              trng_out = 1'b0;
    logic              word_ready = 1'b0;
    logic              trng_reset;
    logic              word_valid;
    logic              fault;
    logic              busy;
    logic [c_WW-1:0]   word_data;
    logic [c_DW-1:0]   drop_cnt;
`ifdef TRNG_CTRL_ONES_CNT_EN
    logic [c_OW-1:0]   word_ones;
`endif

    always #5 clk = ~clk;

    trng_ctrl #(
        .WORD_W   (c_WW),
        .WARMUP   (c_WU),
        .RC_LIMIT (c_RCL),
        .DROP_W   (c_DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .clear_fault    (clear_fault),
        .trng_reset     (trng_reset),
        .trng_out_valid (trng_out_valid),
        .trng_out       (trng_out),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .word_data      (word_data),
`ifdef TRNG_CTRL_ONES_CNT_EN
        .word_ones      (word_ones),
`endif
        .fault          (fault),
        .busy           (busy),
        .drop_cnt       (drop_cnt)
    );

    // Reference model: mode 0 idle, 1 warm-up, 2 run, 3 fault; partial word as a bit queue.
    int   m_mode;
    int   m_wu;
    int   m_run;
    bit   m_last;
    bit   m_bits[$];
    bit   m_wv;
    int   m_wd;
    int   m_wo;
    int   m_drop;

    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp;
        int         ones;
    } vec_t;
    vec_t tbl[6];

    task automatic m_reset();
        m_mode = 0; m_wu = 0; m_run = 0; m_last = 1'b0;
        m_bits.delete();
        m_wv = 1'b0; m_wd = 0; m_wo = 0; m_drop = 0;
    endtask

    task automatic m_step(input logic en, input logic clr, input logic v,
                          input logic b, input logic rdy);
        bit done;
        int nw;
        done = 1'b0;
        nw   = 0;
        case (m_mode)
            0: if (en) begin
                m_mode = 1; m_wu = 0; m_run = 0; m_bits.delete();
            end
            1: if (!en) m_mode = 0;
               else if (v) begin
                   m_wu++;
                   if (m_wu == c_WU) m_mode = 2;
               end
            2: if (!en) begin
                   m_mode = 0; m_bits.delete();
               end else if (v) begin
                   m_run  = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
                   m_last = b;
                   if (m_run == c_RCL) begin
                       m_mode = 3; m_bits.delete();
                   end else begin
                       m_bits.push_back(b);
                       if (m_bits.size() == c_WW) begin
                           done = 1'b1;
                           foreach (m_bits[i]) nw = nw | (int'(m_bits[i]) << i);
                           m_bits.delete();
                       end
                   end
               end
            default: if (clr) m_mode = 0;
        endcase
        if (done) begin
            if (!m_wv || rdy) begin
                m_wv = 1'b1; m_wd = nw; m_wo = $countones(nw);
            end else if (m_drop < (1 << c_DW) - 1) begin
                m_drop++;
            end
        end else if (m_wv && rdy) begin
            m_wv = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic ok;
        n_cmp++;
        ok = (word_valid === m_wv) && (word_data === c_WW'(m_wd)) &&
             (fault === (m_mode == 3)) && (busy === (m_mode == 1 || m_mode == 2)) &&
             (trng_reset === (m_mode == 0 || m_mode == 3)) && (drop_cnt === c_DW'(m_drop));
`ifdef TRNG_CTRL_ONES_CNT_EN
        ok = ok && (word_ones === c_OW'(m_wo));
`endif
        if (!ok) begin
            n_err++;
            $display("FAIL %s @%0t: got v=%0b d=%h f=%0b busy=%0b rst=%0b drop=%0d, expected v=%0b d=%h f=%0b busy=%0b rst=%0b drop=%0d",
                     tag, $time, word_valid, word_data, fault, busy, trng_reset, drop_cnt,
                     m_wv, c_WW'(m_wd), (m_mode == 3), (m_mode == 1 || m_mode == 2),
                     (m_mode == 0 || m_mode == 3), m_drop);
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d (0x%h), expected %0d (0x%h)", nm, $time, got, got, exp, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic clr, input logic v,
                       input logic b, input logic rdy);
        enable = en; clear_fault = clr; trng_out_valid = v; trng_out = b; word_ready = rdy;
        m_step(en, clr, v, b, rdy);
        @(negedge clk);
        check_all("cycle");
    endtask

    task automatic feed_word(input logic [7:0] w, input logic rdy);
        for (int i = 0; i < c_WW; i++) cyc(1'b1, 1'b0, 1'b1, w[i], rdy);
    endtask

    initial begin
        tbl[0] = '{8'hAA, 8'hAA, 4};
        tbl[1] = '{8'h55, 8'h55, 4};
        tbl[2] = '{8'hF1, 8'hF1, 5};
        tbl[3] = '{8'h36, 8'h36, 4};
        tbl[4] = '{8'h93, 8'h93, 4};
        tbl[5] = '{8'h6C, 8'h6C, 4};

        m_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_all("reset_state");
        chk("reset_trng_reset", int'(trng_reset), 1);

        // Warm-up discards 0,1,0,1, then table words stream out with ready high.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < c_WU; i++) cyc(1'b1, 1'b0, 1'b1, 1'(i % 2), 1'b1);
        for (int t = 0; t < 6; t++) begin
            feed_word(tbl[t].data, 1'b1);
            chk("tbl_word_valid", int'(word_valid), 1);
            chk("tbl_word_data", int'(word_data), int'(tbl[t].exp));
`ifdef TRNG_CTRL_ONES_CNT_EN
            chk("tbl_word_ones", int'(word_ones), tbl[t].ones);
`endif
            if (t == 0) chk("first_word_drop_cnt", int'(drop_cnt), 0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("tbl_flush_valid", int'(word_valid), 0);

        // Back-pressure: three words with ready low, then one accept cycle.
        feed_word(8'hA5, 1'b0);
        feed_word(8'h5A, 1'b0);
        feed_word(8'hA5, 1'b0);
        chk("held_word_data", int'(word_data), 8'hA5);
        chk("held_drop_cnt", int'(drop_cnt), 2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("after_take_valid", int'(word_valid), 0);
        feed_word(8'h5A, 1'b0);
        feed_word(8'hA5, 1'b0);
        feed_word(8'h5A, 1'b0);
        chk("drop_cnt_saturated", int'(drop_cnt), 3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Five ones end on the 8th bit: the trip wins over word completion.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("trip_fault", int'(fault), 1);
        chk("trip_trng_reset", int'(trng_reset), 1);
        chk("trip_no_word", int'(word_valid), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("fault_sticky_enable_low", int'(fault), 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("clear_fault", int'(fault), 0);
        chk("clear_busy", int'(busy), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("restart_busy", int'(busy), 1);

        // Drop enable mid-word: warm-up must repeat before the next word.
        for (int i = 0; i < c_WU; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("disable_busy", int'(busy), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < c_WU; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        feed_word(8'h55, 1'b1);
        chk("rewarm_word", int'(word_data), 8'h55);

        // Asynchronous reset while a word is held in RUN.
        feed_word(8'h33, 1'b0);
        chk("pre_reset_valid", int'(word_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", int'(word_valid), 0);
        chk("async_rst_trng_reset", int'(trng_reset), 1);
        chk("async_rst_drop", int'(drop_cnt), 0);
        chk("async_rst_busy", int'(busy), 0);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        check_all("post_reset");

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            logic en;
            logic clr;
            en  = ($urandom_range(0, 63) != 0);
            clr = (m_mode == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
            cyc(en, clr, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/trng_ctrl.md
Name: trng_ctrl

Overview:
- Sequencer and output scheduler for the `trng` core (`clk`, `reset`, `latch_bit` in; `out_valid`, `out` out).
- Holds the core in reset until enabled, then discards a warm-up run of debiased bits.
- Packs the remaining bits into words with a repetition-count health test, and serves words to one consumer over a valid/ready handshake.
- Sits between the `trng` instance and the system bus / bit-dump logic.

Parameters:
- WORD_W, 32: output word width, ≥2.
- WARMUP, 64: number of `trng` `out_valid` bits discarded after start; 0 means no discard.
- RC_LIMIT, 34: consecutive identical valid bits that trip FAULT; ≥2.
- DROP_W, 8: width of the dropped-word counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = run the core.
- clear_fault  in  1  pulse; leaves FAULT.
- trng_reset  out  1  drives `trng.reset`.
- trng_out_valid  in  1  from `trng.out_valid`.
- trng_out  in  1  from `trng.out`.
- word_valid  out  1  output word available.
- word_ready  in  1  consumer accepts the word.
- word_data  out  WORD_W  output word; first received bit in the LSB.
- fault  out  1  health-test failure, sticky.
- busy  out  1  state is WARMUP or RUN.
- drop_cnt  out  DROP_W  count of dropped words, saturating.

Behaviour:
- Clock and reset: single clock domain `clk`. `reset` is asynchronous and active-high.
- Reset values: state=IDLE, trng_reset=1, word_valid=0, word_data=0, fault=0, busy=0, drop_cnt=0, pack count=0, rc count=0.
- FSM states are IDLE, WARMUP, RUN, FAULT.
- IDLE:
  - trng_reset=1.
  - If enable=1, go to WARMUP next cycle. Also clear the warm-up counter, pack count, rc count and last-bit.
- WARMUP:
  - trng_reset=0.
  - Each cycle with trng_out_valid=1 increments the warm-up counter. The bit is discarded and not health-tested.
  - When the counter reaches WARMUP, go to RUN. With WARMUP=0, go to RUN on the first cycle.
- RUN:
  - trng_reset=0.
  - Each valid bit is shifted into the pack register at index pack_cnt, and also goes to the health test.
  - Health test: if the bit equals last_bit, rc_cnt increments, otherwise rc_cnt=1. The first bit after entering RUN sets rc_cnt=1.
  - If rc_cnt reaches RC_LIMIT, go to FAULT. The word containing that bit is discarded.
- Word completion (when pack_cnt hits WORD_W):
  - If word_valid=0, or word_valid=1 with word_ready=1 in the same cycle: load word_data and set word_valid=1 on the next cycle.
  - Otherwise drop the new word, keep the held word, and increment drop_cnt, saturating at all-ones.
  - pack_cnt wraps to 0.
- Handshake:
  - Transfer happens when word_valid && word_ready.
  - word_data is stable while word_valid=1 and word_ready=0.
  - word_valid falls the cycle after a transfer unless a new word loads in the same cycle.
  - Latency: word_valid rises 1 cycle after the cycle carrying bit WORD_W-1.
- FAULT:
  - trng_reset=1 and fault=1.
  - The pack register is cleared. A held output word is still deliverable.
  - clear_fault=1: go to IDLE and set fault=0.
- enable=0 in WARMUP or RUN:
  - Go to IDLE next cycle and discard the partial word.
  - A held word stays valid until taken.
- enable=0 in FAULT: state stays FAULT, because only clear_fault exits it.
- Outputs:
  - busy = (state==WARMUP || state==RUN).
  - trng_reset is a registered output. It is high in IDLE and FAULT and during reset.
- Simultaneous events:
  - The health-test trip has priority over word completion.
  - enable=0 has priority over an arriving bit.
  - clear_fault and enable=1 in the same cycle go to IDLE; WARMUP starts the following cycle.
- Bits arriving in IDLE or FAULT are ignored.

Optional Feature:
- Macro: TRNG_CTRL_ONES_CNT_EN.
- Defined:
  - Adds output port word_ones, width $clog2(WORD_W+1), carrying the number of 1 bits in word_data.
  - It is computed incrementally during packing and registered with word_data. It is stable under the same rules.
  - Reset value is 0.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package trng_pkg:
  - state enum: IDLE=2'd0, WARMUP=2'd1, RUN=2'd2, FAULT=2'd3.
  - default constants for WORD_W, WARMUP and RC_LIMIT.
- Sub-module trng_rc_health:
  - Inputs: clk, reset, clr, bit_valid, bit_in.
  - Output: trip.
  - Contains the rc counter and last-bit register.
- Packing, handshake and the FSM stay in the top module.

Test Plan:
- Enable with WARMUP=4, WORD_W=8, feed alternating bits 0,1,0,1… on every cycle -> first 4 bits discarded; word_data=8'hAA with word_valid=1 one cycle after the 12th valid bit; drop_cnt=0.
- Hold word_ready=0 across 3 completed words -> first word held unchanged; drop_cnt=2; then word_ready=1 for one cycle -> word_valid=0 on the next cycle.
- RC_LIMIT=5, feed 5 consecutive 1s in RUN -> fault=1 and trng_reset=1 on the next cycle; partial word discarded; clear_fault pulse -> IDLE with fault=0.
- Drop enable mid-word after 3 bits, then re-enable -> full WARMUP repeats; next word contains only post-warm-up bits.
- Assert reset while word_valid=1 and state=RUN -> immediately word_valid=0, trng_reset=1, drop_cnt=0, state IDLE.
- With TRNG_CTRL_ONES_CNT_EN defined, WORD_W=8, bits produce word 8'hF1 -> word_ones=5.
